fifo_sync_param: RTL and testbench

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ram.sv | 32 +++
 rtl/fifo_sync_param.sv | 103 ++++++++++
 tb/tb_fifo_sync_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO.
//   cnt_w(depth) : width of the occupancy counter, holds 0..depth inclusive
//   ptr_w(depth) : width of a read/write pointer, indexes 0..depth-1
//   DEF_*        : default parameter values used by the FIFO modules
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    // almost_full defaults to DEPTH minus this margin
    localparam int DEF_AF_MARGIN = 2;
    localparam int DEF_AE_LEVEL  = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that count == depth is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: WIDTH x DEPTH, one synchronous write port, one
// asynchronous read port, no reset (contents are don't-care after reset).
// Ports:
//   clk   - clock
//   we    - write enable (already qualified by the controller)
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
module fifo_ram import fifo_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read sees the pre-edge contents, so a simultaneous read/write at
    // full (same address) returns the old head as required.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parameterised single-clock FIFO with registered count/flags and
// one-cycle overflow/underflow pulses.
// Optional macro FIFO_FWFT_EN: first-word-fall-through output
// (head visible whenever not empty, 0 while empty). Undefined: data_out
// is registered and updates on the edge that accepts a read.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   we, re          - write / read requests
//   data_in         - write data
//   data_out        - read data
//   full, empty     - count == DEPTH / count == 0
//   almost_full     - count >= AF_LEVEL
//   almost_empty    - count <= AE_LEVEL
//   count           - occupancy 0..DEPTH
//   overflow        - pulse: write rejected on previous edge
//   underflow       - pulse: read rejected on previous edge
module fifo_sync_param import fifo_pkg::*; #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic                      re,
    input  logic [WIDTH-1:0]          data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] rd_data;
    logic             wr_acc, rd_acc;

    // A write at full is still taken when a read frees the slot this edge.
    assign wr_acc  = we && (!full || re);
    assign rd_acc  = re && !empty;
    assign cnt_nxt = count + CW'(wr_acc) - CW'(rd_acc);

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Flags are registered off the next count so they line up with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            count        <= cnt_nxt;
            full         <= (cnt_nxt == CW'(DEPTH));
            empty        <= (cnt_nxt == '0);
            almost_full  <= (cnt_nxt >= CW'(AF_LEVEL));
            almost_empty <= (cnt_nxt <= CW'(AE_LEVEL));
            overflow     <= we && full && !re;
            underflow    <= re && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // empty and rd_ptr are registered, so this is glitch-free head data.
    assign data_out = empty ? '0 : rd_data;
`else
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (rst)         dout_q <= '0;
        else if (rd_acc) dout_q <= rd_data;
    end

    assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             we = 1'b0, re = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             full, empty, almost_full, almost_empty;
    logic [4:0]       count;
    logic             overflow, underflow;

    fifo_sync_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .re           (re),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus expected outputs.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout = '0;
    logic             exp_ovf  = 1'b0;
    logic             exp_unf  = 1'b0;
    int               tests = 0, fails = 0;
    int               ovf_seen, unf_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},    32'(count),        32'(n));
        chk({tag, ".full"},     32'(full),         32'(n == DEPTH));
        chk({tag, ".empty"},    32'(empty),        32'(n == 0));
        chk({tag, ".afull"},    32'(almost_full),  32'(n >= AF));
        chk({tag, ".aempty"},   32'(almost_empty), 32'(n <= AE));
        chk({tag, ".overflow"}, 32'(overflow),     32'(exp_ovf));
        chk({tag, ".underflow"},32'(underflow),    32'(exp_unf));
        chk({tag, ".data_out"}, 32'(data_out),     32'(exp_dout));
    endtask

    // One clock with the given request; model applies the FIFO rules
    // against the pre-edge occupancy, then all outputs are compared.
    task automatic step(input string tag, input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit was_full, was_empty, racc, wacc;
        logic [WIDTH-1:0] popped;
        we = w; re = r; data_in = d;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        racc = r && !was_empty;
        wacc = w && (!was_full || r);
        @(posedge clk);
        popped = '0;
        if (racc) popped = q.pop_front();
        if (wacc) q.push_back(d);
        exp_ovf = w && was_full && !r;
        exp_unf = r && was_empty;
`ifdef FIFO_FWFT_EN
        exp_dout = (q.size() != 0) ? q[0] : '0;
`else
        if (racc) exp_dout = popped;
`endif
        #1;
        chk_all(tag);
        we = 1'b0; re = 1'b0;
        if (overflow)  ovf_seen++;
        if (underflow) unf_seen++;
    endtask

    task automatic do_reset(input string tag, input logic w, input logic r);
        rst = 1'b1; we = w; re = r; data_in = 8'hEE;
        @(posedge clk);
        q.delete();
        exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
        #1;
        rst = 1'b0; we = 1'b0; re = 1'b0;
        chk_all(tag);
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset", 1'b0, 1'b0);

        // Fill past full: the 17th write must be dropped.
        ovf_seen = 0;
        for (int i = 0; i < 17; i++) begin
            step("fill", 1'b1, 1'b0, 8'(i));
            if (i == 15) chk("fill.full16", 32'(full), 32'd1);
        end
        chk("fill.ovf_once", 32'(ovf_seen), 32'd1);

        // Drain past empty: data 00..0F in order, 10 never appears.
        unf_seen = 0;
        for (int i = 0; i < 17; i++) begin
            step("drain", 1'b0, 1'b1, 8'h00);
`ifndef FIFO_FWFT_EN
            if (i < 16) chk("drain.order", 32'(data_out), 32'(i));
`endif
        end
        chk("drain.empty", 32'(empty), 32'd1);
        chk("drain.unf_once", 32'(unf_seen), 32'd1);

        // Occupancy sweep 0 -> 16 -> 0, flags checked every step.
        for (int i = 0; i < 16; i++) step("sweep_up", 1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 16; i++) step("sweep_dn", 1'b0, 1'b1, 8'h00);

        // Simultaneous read/write at full and at empty.
        for (int i = 0; i < 16; i++) step("prefill", 1'b1, 1'b0, 8'($urandom));
        step("rw_full", 1'b1, 1'b1, 8'h5A);
        chk("rw_full.count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) step("predrain", 1'b0, 1'b1, 8'h00);
        step("rw_empty", 1'b1, 1'b1, 8'hC3);
        chk("rw_empty.count", 32'(count), 32'd1);
        chk("rw_empty.unf", 32'(underflow), 32'd1);

        // Mixed random traffic exercising pointer wrap.
        for (int i = 0; i < 40; i++)
            step("mixed", 1'($urandom), 1'($urandom), 8'($urandom));

        // Reset mid-stream at count 9 with both requests active.
        while (q.size() < 9) step("to9", 1'b1, 1'b0, 8'($urandom));
        while (q.size() > 9) step("to9", 1'b0, 1'b1, 8'h00);
        chk("pre_rst.count", 32'(count), 32'd9);
        do_reset("rst_mid", 1'b1, 1'b1);
        step("post_rst_w", 1'b1, 1'b0, 8'h77);
        step("post_rst_r", 1'b0, 1'b1, 8'h00);
        chk("post_rst.data", 32'(data_out), 32'h77);

`ifdef FIFO_FWFT_EN
        step("fwft_w", 1'b1, 1'b0, 8'hA5);
        step("fwft_idle", 1'b0, 1'b0, 8'h00);
        chk("fwft.head", 32'(data_out), 32'hA5);
        step("fwft_pop", 1'b0, 1'b1, 8'h00);
        chk("fwft.zero", 32'(data_out), 32'h0);
`endif

        // Longer random run, biased toward the boundaries.
        for (int i = 0; i < 300; i++) begin
            bit w, r;
            w = ($urandom_range(0, 9) < ((i / 50) % 2 ? 3 : 7));
            r = ($urandom_range(0, 9) < ((i / 50) % 2 ? 7 : 3));
            step("rand", w, r, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
